// File: rtl/alarm_controller.sv
// Arm/disarm alarm controller with exit/entry delays, bad-code lockout and a
// bounded alarm period. Optional blinking Y in ALARM when ALARM_BLINK_EN is defined.
module alarm_controller #(
  parameter int         EXIT_DELAY  = 8,
  parameter int         ENTRY_DELAY = 8,
  parameter int         ALARM_TIME  = 32,
  parameter logic [3:0] CODE        = 4'hA,
  parameter int         CNT_W       = 8,
  parameter int         BLINK_HALF  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm,
  input  logic       sensor,
  input  logic [3:0] code,
  input  logic       code_valid,
  output logic       Y,
  output logic       armed,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_DIS    = 3'd0,
    S_ARMING = 3'd1,
    S_ARMED  = 3'd2,
    S_ENTRY  = 3'd3,
    S_ALARM  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] L_EXIT  = CNT_W'(EXIT_DELAY - 1);
  localparam logic [CNT_W-1:0] L_ENTRY = CNT_W'(ENTRY_DELAY - 1);
  localparam logic [CNT_W-1:0] L_ALARM = CNT_W'(ALARM_TIME - 1);

  state_t           r_state, w_nxt;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
  logic [1:0]       r_bad, w_nxt_bad;
  logic             r_y, r_armed;
  logic             w_good, w_bad, w_bad3;

  assign w_good = code_valid & (code == CODE);
  assign w_bad  = code_valid & (code != CODE);
  assign w_bad3 = w_bad & (r_bad == 2'd2);

  always_comb begin
    w_nxt     = r_state;
    w_nxt_cnt = r_cnt;
    w_nxt_bad = r_bad;
    if (r_state != S_DIS && w_good) begin
      w_nxt     = S_DIS;
      w_nxt_cnt = '0;
      w_nxt_bad = '0;
    end else begin
      case (r_state)
        S_DIS: if (arm) begin
          w_nxt     = S_ARMING;
          w_nxt_cnt = L_EXIT;
        end
        S_ARMING: begin
          if (r_cnt == '0) w_nxt = S_ARMED;
          else             w_nxt_cnt = r_cnt - 1'b1;
        end
        // third bad outranks a simultaneous sensor trip
        S_ARMED: begin
          if (w_bad3) begin
            w_nxt     = S_ALARM;
            w_nxt_cnt = L_ALARM;
            w_nxt_bad = 2'd3;
          end else begin
            if (w_bad && r_bad != 2'd3) w_nxt_bad = r_bad + 1'b1;
            if (sensor) begin
              w_nxt     = S_ENTRY;
              w_nxt_cnt = L_ENTRY;
            end
          end
        end
        S_ENTRY: begin
          if (w_bad3) begin
            w_nxt     = S_ALARM;
            w_nxt_cnt = L_ALARM;
            w_nxt_bad = 2'd3;
          end else begin
            if (w_bad && r_bad != 2'd3) w_nxt_bad = r_bad + 1'b1;
            if (r_cnt == '0) begin
              w_nxt     = S_ALARM;
              w_nxt_cnt = L_ALARM;
            end else begin
              w_nxt_cnt = r_cnt - 1'b1;
            end
          end
        end
        S_ALARM: begin
          if (r_cnt == '0) begin
            w_nxt     = S_ARMED;
            w_nxt_cnt = '0;
            w_nxt_bad = '0;
          end else begin
            w_nxt_cnt = r_cnt - 1'b1;
          end
        end
        default: begin
          w_nxt     = S_DIS;
          w_nxt_cnt = '0;
          w_nxt_bad = '0;
        end
      endcase
    end
  end

`ifdef ALARM_BLINK_EN
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] L_BH = BW'(BLINK_HALF - 1);
  logic [BW-1:0] r_blink;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_DIS;
      r_cnt   <= '0;
      r_bad   <= '0;
      r_armed <= 1'b0;
      r_y     <= 1'b0;
`ifdef ALARM_BLINK_EN
      r_blink <= '0;
`endif
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_nxt_cnt;
      r_bad   <= w_nxt_bad;
      r_armed <= (w_nxt == S_ARMED) || (w_nxt == S_ENTRY) || (w_nxt == S_ALARM);
`ifdef ALARM_BLINK_EN
      // phase restarts on every ALARM entry; Y is low again on the exit edge
      if (w_nxt == S_ALARM && r_state != S_ALARM) begin
        r_y     <= 1'b1;
        r_blink <= L_BH;
      end else if (w_nxt == S_ALARM) begin
        if (r_blink == '0) begin
          r_y     <= ~r_y;
          r_blink <= L_BH;
        end else begin
          r_blink <= r_blink - 1'b1;
        end
      end else begin
        r_y     <= 1'b0;
        r_blink <= '0;
      end
`else
      r_y <= (w_nxt == S_ALARM);
`endif
    end
  end

  assign Y     = r_y;
  assign armed = r_armed;
  assign state = r_state;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: arming, entry/alarm timing, code handling,
// priorities and mid-alarm reset, with hand-derived expected state/Y/armed.
module tb_alarm_controller;
  localparam int BH = 4;

  logic       clk = 1'b0;
  logic       rst, arm, sensor, code_valid;
  logic [3:0] code;
  logic       Y, armed;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  alarm_controller dut (
    .clk(clk), .rst(rst), .arm(arm), .sensor(sensor), .code(code),
    .code_valid(code_valid), .Y(Y), .armed(armed), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int yexp(input int i);
`ifdef ALARM_BLINK_EN
    return ((i / BH) % 2 == 0) ? 1 : 0;
`else
    return (i >= 0) ? 1 : 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n edges, each expected to leave the FSM in st; i0 is the ALARM cycle index
  task automatic hold(input string tag, input int st, input int n, input int i0);
    for (int k = 0; k < n; k++) begin
      tick();
      chk({tag, ".state"}, 32'(state), st);
      chk({tag, ".Y"}, 32'(Y), (st == 4) ? yexp(i0 + k) : 0);
      chk({tag, ".armed"}, 32'(armed), (st >= 2 && st <= 4) ? 1 : 0);
    end
  endtask

  task automatic strobe(input string tag, input logic [3:0] c, input int st, input int i0);
    code = c; code_valid = 1'b1;
    hold(tag, st, 1, i0);
    code_valid = 1'b0;
  endtask

  task automatic do_arm(input string tag);
    arm = 1'b1;
    hold(tag, 1, 1, 0);
    arm = 1'b0;
    hold(tag, 1, 7, 0);
    hold(tag, 2, 1, 0);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; sensor = 1'b0; code = 4'h0; code_valid = 1'b0;
    hold("reset", 0, 2, 0);
    rst = 1'b0;

    // exit delay then entry delay then full alarm and auto re-arm
    do_arm("arming");
    sensor = 1'b1;
    hold("entry", 3, 1, 0);
    sensor = 1'b0;
    hold("entry", 3, 7, 0);
    hold("alarm", 4, 32, 0);
    hold("rearm", 2, 1, 0);

    // good code on third ENTRY cycle disarms
    sensor = 1'b1;
    hold("entry2", 3, 1, 0);
    sensor = 1'b0;
    hold("entry2", 3, 2, 0);
    strobe("good_entry", 4'hA, 0, 0);
    hold("disarmed", 0, 2, 0);

    // three bad codes in ARMED -> ALARM
    do_arm("arm2");
    strobe("bad1", 4'h3, 2, 0);
    strobe("bad2", 4'h3, 2, 0);
    strobe("bad3", 4'h3, 4, 0);
    hold("bad_alarm", 4, 31, 1);
    hold("bad_exit", 2, 1, 0);
    // bad count cleared on ALARM exit
    strobe("post_bad1", 4'h3, 2, 0);
    strobe("post_bad2", 4'h3, 2, 0);
    strobe("good_armed", 4'hA, 0, 0);
    do_arm("arm3");
    strobe("restart_bad1", 4'h5, 2, 0);
    strobe("restart_bad2", 4'h5, 2, 0);
    strobe("restart_bad3", 4'h5, 4, 0);
    hold("alarm_mid", 4, 5, 1);
    rst = 1'b1;
    hold("rst_alarm", 0, 1, 0);
    rst = 1'b0;
    hold("after_rst", 0, 1, 0);

    // ENTRY terminal count and good code in same cycle -> DISARMED
    do_arm("arm4");
    sensor = 1'b1;
    hold("entry3", 3, 1, 0);
    sensor = 1'b0;
    hold("entry3", 3, 7, 0);
    strobe("good_terminal", 4'hA, 0, 0);

    // bad in ARMING not counted; sensor + third bad in ARMED -> ALARM
    arm = 1'b1;
    hold("arm5", 1, 1, 0);
    arm = 1'b0;
    strobe("bad_arming", 4'h1, 1, 0);
    hold("arm5", 1, 6, 0);
    hold("arm5", 2, 1, 0);
    strobe("b1", 4'h1, 2, 0);
    strobe("b2", 4'h1, 2, 0);
    sensor = 1'b1;
    strobe("sensor_bad3", 4'h1, 4, 0);
    sensor = 1'b0;
    hold("alarm5", 4, 3, 1);

    // good code in ALARM and in ARMING both disarm
    strobe("good_alarm", 4'hA, 0, 0);
    arm = 1'b1;
    hold("arm6", 1, 1, 0);
    arm = 1'b0;
    hold("arm6", 1, 2, 0);
    strobe("good_arming", 4'hA, 0, 0);
    // code and sensor ignored in DISARMED
    sensor = 1'b1;
    strobe("dis_ignore", 4'h3, 0, 0);
    sensor = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
